// File: rtl/ps2_rx_frame_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame decoder and show-ahead frame FIFO.
// Define PS2_RX_TIMEOUT_EN to build the stalled-frame timeout (error code 11).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a start bit (data=0) on a filtered clock fall
// ST_DATA   | shifting in DATA_BITS data bits, LSB first
// ST_PARITY | checking the parity bit against the received data
// ST_STOP   | checking the stop bit
// ST_PUSH   | one cycle: write {code, data} into the FIFO
module ps2_rx_frame_fifo #(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CLK_MOUSE_IN,
  input  logic                          DATA_MOUSE_IN,
  input  logic                          READ_ENABLE,
  input  logic                          POP,
  output logic [DATA_BITS-1:0]          BYTE_READ,
  output logic [1:0]                    BYTE_ERROR_CODE,
  output logic                          BYTE_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVERFLOW,
  output logic                          BUSY
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int CW      = $clog2(DATA_BITS + 1);
  localparam int FW      = $clog2(FILTER_LEN + 1);
  localparam int ENTRY_W = DATA_BITS + 2;
  localparam logic PAR_ODD = (PARITY_MODE == 1);

  if (TIMEOUT_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SYNC_STAGES < 2 || FILTER_LEN < 1 || DATA_BITS < 5 || DATA_BITS > 9) begin : g_param_check
    $error("ps2_rx_frame_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP, ST_PUSH} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;
  logic                   filt_q, filt_d, fall;
  logic [FW-1:0]          filt_cnt;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], CLK_MOUSE_IN};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], DATA_MOUSE_IN};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      filt_q   <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= FW'(FILTER_LEN - 1);
    end else begin
      filt_d <= filt_q;
      if (clk_s != filt_q) begin
        if (filt_cnt == '0) begin
          filt_q   <= clk_s;
          filt_cnt <= FW'(FILTER_LEN - 1);
        end else begin
          filt_cnt <= filt_cnt - FW'(1);
        end
      end else begin
        filt_cnt <= FW'(FILTER_LEN - 1);
      end
    end
  end

  assign fall = filt_d & ~filt_q;

  state_t               state_q, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [1:0]           code_q, code_n;
  logic                 tmr_tc;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;

  // Reaches zero TIMEOUT_CYCLES cycles after the last fall.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      tmr_q <= TW'(TIMEOUT_CYCLES - 1);
    else if (fall || state_q == ST_IDLE)
      tmr_q <= TW'(TIMEOUT_CYCLES - 1);
    else if (tmr_q != '0)
      tmr_q <= tmr_q - TW'(1);
  end

  assign tmr_tc = (tmr_q == '0) && !fall &&
                  (state_q == ST_DATA || state_q == ST_PARITY || state_q == ST_STOP);
`else
  assign tmr_tc = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      cnt_q   <= cnt_n;
      code_q  <= code_n;
    end
  end

  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    cnt_n   = cnt_q;
    code_n  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (fall && READ_ENABLE && !dat_s) begin
          state_n = ST_DATA;
          cnt_n   = '0;
          code_n  = 2'b00;
        end
      end
      ST_DATA: begin
        if (tmr_tc) begin
          state_n = ST_PUSH;
          code_n  = 2'b11;
        end else if (fall) begin
          shift_n = {dat_s, shift_q[DATA_BITS-1:1]};
          cnt_n   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_BITS - 1))
            state_n = (PARITY_MODE == 0) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (tmr_tc) begin
          state_n = ST_PUSH;
          code_n  = 2'b11;
        end else if (fall) begin
          if (((^shift_q) ^ dat_s) != PAR_ODD)
            code_n = 2'b01;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tmr_tc) begin
          state_n = ST_PUSH;
          code_n  = 2'b11;
        end else if (fall) begin
          if (!dat_s)
            code_n = 2'b10;
          state_n = ST_PUSH;
        end
      end
      ST_PUSH: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] wdata, head_q;
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_n;
  logic [LW-1:0]      level_q, level_n;
  logic               push_req, full, do_pop, do_push, head_from_wr, ovf_q;

  assign push_req = (state_q == ST_PUSH);
  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign do_pop   = POP && (level_q != '0);
  assign do_push  = push_req && (!full || do_pop);
  assign wdata    = {code_q, shift_q};
  assign rd_n     = do_pop ? rd_ptr + AW'(1) : rd_ptr;
  // The entry being written becomes the head when nothing else remains after this cycle's pop.
  assign head_from_wr = do_push && ((level_q == '0) || (level_q == LW'(1) && do_pop));

  always_comb begin
    level_n = level_q;
    case ({do_push, do_pop})
      2'b10:   level_n = level_q + LW'(1);
      2'b01:   level_n = level_q - LW'(1);
      default: level_n = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  // The head is registered so it holds its last value once the FIFO drains.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_n;
      level_q <= level_n;
      if (level_n != '0)
        head_q <= head_from_wr ? wdata : mem[rd_n];
      if (push_req && full && !POP)
        ovf_q <= 1'b1;
    end
  end

  assign BYTE_READ       = head_q[DATA_BITS-1:0];
  assign BYTE_ERROR_CODE = head_q[ENTRY_W-1 -: 2];
  assign BYTE_READY      = (level_q != '0);
  assign FIFO_LEVEL      = level_q;
  assign OVERFLOW        = ovf_q;
  assign BUSY            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx_frame_fifo.sv
// Self-checking bench for ps2_rx_frame_fifo: three parameterisations, directed frames plus randomized frames
// checked against a queue model. Timeout checks compile only when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_rx_frame_fifo;
  localparam int S    = 2;
  localparam int F    = 4;
  localparam int HALF = 12;
  localparam int TMO  = 100;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       READ_ENABLE;
  logic [2:0] ps2_c, ps2_d, pop;

  logic [7:0] bread0;  logic [1:0] code0; logic rdy0; logic [2:0] lvl0; logic ovf0; logic busy0;
  logic [8:0] bread1;  logic [1:0] code1; logic rdy1; logic [2:0] lvl1; logic ovf1; logic busy1;
  logic [7:0] bread2;  logic [1:0] code2; logic rdy2; logic [2:0] lvl2; logic ovf2; logic busy2;

  always #5 CLK = ~CLK;

  ps2_rx_frame_fifo #(.DATA_BITS(8), .PARITY_MODE(1), .FIFO_DEPTH(4), .SYNC_STAGES(S),
                      .FILTER_LEN(F), .TIMEOUT_CYCLES(TMO)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(ps2_c[0]), .DATA_MOUSE_IN(ps2_d[0]),
    .READ_ENABLE(READ_ENABLE), .POP(pop[0]), .BYTE_READ(bread0), .BYTE_ERROR_CODE(code0),
    .BYTE_READY(rdy0), .FIFO_LEVEL(lvl0), .OVERFLOW(ovf0), .BUSY(busy0));

  ps2_rx_frame_fifo #(.DATA_BITS(9), .PARITY_MODE(2), .FIFO_DEPTH(4), .SYNC_STAGES(S),
                      .FILTER_LEN(F), .TIMEOUT_CYCLES(TMO)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(ps2_c[1]), .DATA_MOUSE_IN(ps2_d[1]),
    .READ_ENABLE(READ_ENABLE), .POP(pop[1]), .BYTE_READ(bread1), .BYTE_ERROR_CODE(code1),
    .BYTE_READY(rdy1), .FIFO_LEVEL(lvl1), .OVERFLOW(ovf1), .BUSY(busy1));

  ps2_rx_frame_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(4), .SYNC_STAGES(S),
                      .FILTER_LEN(F), .TIMEOUT_CYCLES(TMO)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(ps2_c[2]), .DATA_MOUSE_IN(ps2_d[2]),
    .READ_ENABLE(READ_ENABLE), .POP(pop[2]), .BYTE_READ(bread2), .BYTE_ERROR_CODE(code2),
    .BYTE_READY(rdy2), .FIFO_LEVEL(lvl2), .OVERFLOW(ovf2), .BUSY(busy2));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model for instance 0: entries are (code << 16) | data.
  int exp_q[$];
  bit exp_ovf;
  int last_head;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int frame_code(input int data, input int nbits, input int pmode, input bit pbit,
                                    input bit stopb);
    int ones;
    int code;
    ones = $countones(data & ((1 << nbits) - 1)) + int'(pbit);
    code = 0;
    if (pmode == 1 && (ones % 2) != 1) code = 1;
    if (pmode == 2 && (ones % 2) != 0) code = 1;
    if (!stopb) code = 2;
    return code;
  endfunction

  function automatic bit odd_pbit(input int data);
    return ($countones(data) % 2) == 0;
  endfunction

  function automatic int head_word(input int d);
    case (d)
      0:       return (int'(code0) << 16) | int'(bread0);
      1:       return (int'(code1) << 16) | int'(bread1);
      default: return (int'(code2) << 16) | int'(bread2);
    endcase
  endfunction

  function automatic int rdy(input int d);
    case (d)
      0:       return int'(rdy0);
      1:       return int'(rdy1);
      default: return int'(rdy2);
    endcase
  endfunction

  task automatic ps2_bit(input int d, input bit b, input bit glitch);
    ps2_d[d] = b;
    if (glitch) begin
      repeat (3) @(negedge CLK);
      ps2_c[d] = 1'b0;
      repeat (2) @(negedge CLK);
      ps2_c[d] = 1'b1;
      repeat (HALF - 5) @(negedge CLK);
    end else begin
      repeat (HALF) @(negedge CLK);
    end
    ps2_c[d] = 1'b0;
    repeat (HALF) @(negedge CLK);
    ps2_c[d] = 1'b1;
  endtask

  // lat_mode: 0 plain, 1 check BYTE_READY timing, 2 assert POP in the PUSH cycle.
  // re_mode: 0 enabled, 1 disabled for the whole frame, 2 dropped after the start bit.
  task automatic send_frame(input int d, input int data, input int nbits, input int pmode, input bit pbit,
                            input bit stopb, input bit glitch, input int lat_mode, input int re_mode);
    int code;
    READ_ENABLE = (re_mode != 1);
    ps2_bit(d, 1'b0, glitch);
    if (d == 0) check_val("busy_mid", int'(busy0), int'(re_mode != 1));
    if (re_mode == 2) READ_ENABLE = 1'b0;
    for (int i = 0; i < nbits; i++) ps2_bit(d, bit'((data >> i) & 1), glitch && (i % 3 == 1));
    if (pmode != 0) ps2_bit(d, pbit, 1'b0);
    ps2_d[d] = stopb;
    repeat (HALF) @(negedge CLK);
    ps2_c[d] = 1'b0;
    if (lat_mode != 0) begin
      // Raw fall -> S sync flops -> F filter samples -> fall pulse -> PUSH -> visible.
      repeat (S + F + 1) @(posedge CLK);
      #1;
      check_val("ready_before", rdy(d), int'(exp_q.size() != 0));
      if (lat_mode == 2) pop[d] = 1'b1;
      @(posedge CLK);
      #1;
      pop[d] = 1'b0;
      if (lat_mode == 1) check_val("ready_latency", rdy(d), 1);
      @(negedge CLK);
      repeat (HALF - S - F - 3) @(negedge CLK);
    end else begin
      repeat (HALF) @(negedge CLK);
    end
    ps2_c[d] = 1'b1;
    repeat (HALF) @(negedge CLK);
    READ_ENABLE = 1'b1;
    if (d == 0 && re_mode != 1) begin
      code = frame_code(data, nbits, pmode, pbit, stopb);
      if (lat_mode == 2 && exp_q.size() != 0) last_head = exp_q.pop_front();
      if (exp_q.size() == 4) exp_ovf = 1'b1;
      else exp_q.push_back((code << 16) | (data & ((1 << nbits) - 1)));
    end
  endtask

  task automatic pop_dut(input int d);
    @(negedge CLK);
    pop[d] = 1'b1;
    @(negedge CLK);
    pop[d] = 1'b0;
    if (d == 0 && exp_q.size() != 0) last_head = exp_q.pop_front();
    @(negedge CLK);
  endtask

  task automatic check_state0(input string tag);
    int head;
    head = (exp_q.size() != 0) ? exp_q[0] : last_head;
    check_val({tag, "_level"}, int'(lvl0), exp_q.size());
    check_val({tag, "_ready"}, int'(rdy0), int'(exp_q.size() != 0));
    check_val({tag, "_ovf"},   int'(ovf0), int'(exp_ovf));
    check_val({tag, "_busy"},  int'(busy0), 0);
    check_val({tag, "_head"},  head_word(0), head);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    exp_q.delete();
    exp_ovf   = 1'b0;
    last_head = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int data;
    bit pbit, stopb, gl;
    int re_mode;
    RESET = 1'b0; READ_ENABLE = 1'b1; ps2_c = '1; ps2_d = '1; pop = '0;
    exp_ovf = 1'b0; last_head = 0;
    do_reset();
    check_state0("reset");

    send_frame(0, 'hA5, 8, 1, 1'b1, 1'b1, 1'b0, 1, 0);
    check_state0("a5");
    pop_dut(0);
    check_state0("a5_pop");

    send_frame(0, 'h3C, 8, 1, 1'b0, 1'b1, 1'b0, 0, 0);
    check_state0("bad_par");
    pop_dut(0);
    send_frame(0, 'h3C, 8, 1, 1'b1, 1'b0, 1'b0, 0, 0);
    check_state0("bad_stop");
    pop_dut(0);
    send_frame(0, 'h3C, 8, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    check_state0("bad_both");
    pop_dut(0);
    pop_dut(0);
    check_state0("pop_empty");

    for (int i = 1; i <= 5; i++) send_frame(0, i, 8, 1, odd_pbit(i), 1'b1, 1'b0, 0, 0);
    check_state0("fill5");
    for (int i = 0; i < 4; i++) begin
      pop_dut(0);
      check_state0("drain5");
    end
    do_reset();
    for (int i = 1; i <= 4; i++) send_frame(0, i, 8, 1, odd_pbit(i), 1'b1, 1'b0, 0, 0);
    send_frame(0, 5, 8, 1, odd_pbit(5), 1'b1, 1'b0, 2, 0);
    check_state0("full_pushpop");
    for (int i = 0; i < 4; i++) begin
      pop_dut(0);
      check_state0("drain_pp");
    end

    send_frame(1, 'h1FF, 9, 2, 1'b1, 1'b1, 1'b0, 0, 0);
    check_val("d9_ready", rdy(1), 1);
    check_val("d9_head", head_word(1), 'h1FF);
    pop_dut(1);
    send_frame(1, 'h0F3, 9, 2, 1'b1, 1'b1, 1'b0, 0, 0);
    check_val("d9_bad_par", head_word(1), 'h100F3);
    send_frame(2, 'h80, 8, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    check_val("np_ready", rdy(2), 1);
    check_val("np_head", head_word(2), 'h80);
    pop_dut(2);
    send_frame(2, 'h80, 8, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    check_val("np_bad_stop", head_word(2), 'h20080);

    send_frame(0, 'h5A, 8, 1, odd_pbit('h5A), 1'b1, 1'b1, 0, 0);
    check_state0("glitch");
    send_frame(0, 'h00, 8, 1, odd_pbit(0), 1'b1, 1'b0, 0, 1);
    check_state0("re_off");
    send_frame(0, 'hC3, 8, 1, odd_pbit('hC3), 1'b1, 1'b0, 0, 2);
    check_state0("re_drop");

    ps2_bit(0, 1'b0, 1'b0);
    ps2_bit(0, 1'b1, 1'b0);
    ps2_bit(0, 1'b0, 1'b0);
    RESET = 1'b0;
    #1;
    check_val("rst_mid_level", int'(lvl0), 0);
    check_val("rst_mid_ready", int'(rdy0), 0);
    check_val("rst_mid_busy", int'(busy0), 0);
    check_val("rst_mid_head", head_word(0), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    exp_q.delete(); exp_ovf = 1'b0; last_head = 0;
    repeat (HALF) @(negedge CLK);
    check_state0("after_rst");

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        pop_dut(0);
        check_state0("rnd_pop");
      end else begin
        data  = int'($urandom_range(0, 255));
        pbit  = odd_pbit(data);
        if ($urandom_range(0, 3) == 0) pbit = ~pbit;
        stopb = ($urandom_range(0, 7) != 0);
        gl    = bit'($urandom_range(0, 1));
        re_mode = int'($urandom_range(0, 5));
        re_mode = (re_mode < 4) ? 0 : re_mode - 3;
        send_frame(0, data, 8, 1, pbit, stopb, gl, 0, re_mode);
        check_state0("rnd_frame");
      end
    end

`ifdef PS2_RX_TIMEOUT_EN
    do_reset();
    ps2_bit(0, 1'b0, 1'b0);
    ps2_bit(0, 1'b1, 1'b0);
    ps2_bit(0, 1'b0, 1'b0);
    ps2_d[0] = 1'b1;
    repeat (HALF) @(negedge CLK);
    ps2_c[0] = 1'b0;
    repeat (S + F + TMO + 1) @(posedge CLK);
    #1;
    check_val("tmo_ready_before", int'(rdy0), 0);
    check_val("tmo_busy_before", int'(busy0), 1);
    @(posedge CLK);
    #1;
    check_val("tmo_ready", int'(rdy0), 1);
    @(negedge CLK);
    ps2_c[0] = 1'b1;
    repeat (HALF) @(negedge CLK);
    // Three bits 1,0,1 shifted in from a cleared register land in the top three positions.
    exp_q.push_back((3 << 16) | (5 << 5));
    check_state0("tmo");
    pop_dut(0);
    send_frame(0, 'h3C, 8, 1, odd_pbit('h3C), 1'b1, 1'b0, 0, 0);
    check_state0("tmo_next");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx_frame_fifo.md
Name: ps2_rx_frame_fifo

Overview:
Parametrised next-generation PS/2 device-to-host receiver for the mouse/keyboard front end. Features:
- synchronises and glitch-filters the PS/2 clock and data lines;
- decodes start/data/parity/stop frames with configurable data width and parity mode;
- queues each received frame, with its error code, in a show-ahead FIFO.

This lets the upstream transceiver FSM consume bytes at its own pace without losing any.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first (range 5..9)
PARITY_MODE, 1, 0 = no parity bit, 1 = odd, 2 = even
FIFO_DEPTH, 4, number of frame entries; power of 2, at least 2
SYNC_STAGES, 2, flops in each input synchroniser (at least 2)
FILTER_LEN, 4, consecutive equal samples needed to accept a clock-line level change
TIMEOUT_CYCLES, 20000, CLK cycles with no filtered falling edge before a frame is aborted (used only with the optional feature)

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-low reset; all state clears while RESET=0
CLK_MOUSE_IN  input  1  raw PS/2 clock line
DATA_MOUSE_IN  input  1  raw PS/2 data line
READ_ENABLE  input  1  permits start of a new frame; an in-progress frame always completes
POP  input  1  removes the FIFO head entry; ignored when FIFO is empty
BYTE_READ  output  DATA_BITS  head entry data (show-ahead)
BYTE_ERROR_CODE  output  2  head entry code: 00 ok, 01 parity, 10 stop, 11 timeout
BYTE_READY  output  1  FIFO not empty
FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  entries held
OVERFLOW  output  1  sticky; a completed frame was dropped because the FIFO was full
BUSY  output  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, shift register 0, filter output 1.
- Input path:
  - both lines pass through SYNC_STAGES flops;
  - the synced clock feeds the filter; the filter output changes only after FILTER_LEN consecutive samples differ from it;
  - fall = filter output was 1 last cycle and is 0 now; single-cycle pulse;
  - data is sampled from the synced data line in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP, PUSH. All transitions occur on fall, except those out of PUSH.
  - IDLE: on fall with READ_ENABLE=1 and data=0, go to DATA; clear bit count and error code. On fall with data=1 or READ_ENABLE=0, stay in IDLE.
  - DATA: on fall, shift right with the sampled bit into the MSB and increment the count. On the DATA_BITS-th bit, go to PARITY, or to STOP if PARITY_MODE=0. There is no idle cycle between the last data bit and the parity bit.
  - PARITY: if XOR(data, parity bit) is not 1 (odd mode) or not 0 (even mode), set code 01. Go to STOP.
  - STOP: if the sampled bit is 0, set code 10; this overrides 01. Go to PUSH.
  - PUSH: one cycle. Write {code, data} to the FIFO and return to IDLE. If the FIFO is full and POP=0, drop the frame and set OVERFLOW.
- Latency: stop fall in cycle T, PUSH in T+1, entry visible (BYTE_READY=1, FIFO_LEVEL incremented) in T+2.
- FIFO rules:
  - POP with the FIFO empty has no effect.
  - Push and pop in the same cycle keep the level unchanged; when full this is not an overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - BYTE_READ and BYTE_ERROR_CODE hold their last value when the FIFO is empty.
- OVERFLOW clears only on reset.
- READ_ENABLE falling mid-frame does not abort the frame.
- RESET asserted mid-frame: the partial frame is discarded and the FIFO is emptied immediately (asynchronous).

Optional Feature:
PS2_RX_TIMEOUT_EN
- Defined:
  - a counter restarts on every fall and while in IDLE;
  - in DATA, PARITY or STOP, reaching TIMEOUT_CYCLES forces PUSH with code 11, pushing the partial shift-register contents, then IDLE;
  - the timeout code takes precedence over 01 and 10.
- Not defined:
  - no counter is built and code 11 is never produced;
  - a stalled frame waits indefinitely until more edges arrive or reset.

Test Plan:
1. Defaults; send frame 0xA5, odd parity bit 1, stop 1 -> BYTE_READY=1 exactly 2 cycles after the stop fall; BYTE_READ=0xA5, code 00, FIFO_LEVEL=1; POP -> BYTE_READY=0.
2. Frame 0x3C with parity bit 0 (wrong for odd) -> code 01. Frame 0x3C, correct parity, stop=0 -> code 10. Bad parity plus bad stop -> code 10.
3. FIFO_DEPTH=4: send 5 frames 0x01..0x05 with no POP -> FIFO_LEVEL=4, OVERFLOW=1, pops return 0x01..0x04. Repeat with POP asserted in the 5th frame's PUSH cycle -> no overflow; 0x05 retained.
4. DATA_BITS=9, PARITY_MODE=2: send 0x1FF with even parity bit 1 -> BYTE_READ=0x1FF, code 00. PARITY_MODE=0: 8-bit frame 0x80, stop=1 -> code 00.
5. Inject 2-cycle low glitches on CLK_MOUSE_IN (FILTER_LEN=4) during a frame -> no extra bits; data intact. READ_ENABLE=0 at the start bit -> nothing queued.
6. PS2_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: stop clocking after 3 data bits -> entry with code 11 appears 101..102 cycles after the last fall; BUSY=0; the next valid frame decodes with code 00.
